// File: rtl/sync_up_counter.sv
// rtl/sync_up_counter.sv - programmable-modulus up counter with wrap/saturate, sticky overflow and cascade carry
module sync_up_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] mod_max,
   input  logic             sat,
   output logic [WIDTH-1:0] qOut,
   output logic             tc,
   output logic             carry,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   // Count has reached the top of its natural range: either the programmed
   // terminal, or all-ones after a load parked it above the terminal.
   logic at_top;

   // Terminal detect and cascade enable, live against the current mod_max
   always_comb begin
      tc     = (qOut == mod_max);
      carry  = tc & en & ~clr & ~load;
      at_top = tc | (qOut == ALL_ONES);
   end

   // Count and sticky overflow: rst > clr > load > en > hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         qOut <= '0;
         ovf  <= 1'b0;
      end else if (clr) begin
         qOut <= '0;
         ovf  <= 1'b0;
      end else if (load) begin
         qOut <= load_val;
      end else if (en) begin
         if (!at_top) begin
            qOut <= qOut + 1'b1;
         end else if (!sat) begin
            qOut <= '0;
            ovf  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sync_up_counter.sv
// tb/tb_sync_up_counter.sv - self-checking bench for sync_up_counter
module tb_sync_up_counter;

   localparam int W    = 4;
   localparam int MODV = 16;

   logic         clk = 1'b0;
   logic         rst, en, clr, load, sat;
   logic [W-1:0] load_val, mod_max;
   logic [W-1:0] qOut;
   logic         tc, carry, ovf;

   // cascade pair
   logic         cas_en;
   logic [W-1:0] c_mod, c_zero;
   logic         c_zero1;
   logic [W-1:0] q0, q1;
   logic         tc0, tc1, carry0, carry1, ovf0, ovf1;

   int errors = 0;
   int checks = 0;
   int m_q, m_ovf;

   always #5 clk = ~clk;

   sync_up_counter #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
      .load_val(load_val), .mod_max(mod_max), .sat(sat),
      .qOut(qOut), .tc(tc), .carry(carry), .ovf(ovf)
   );

   sync_up_counter #(.WIDTH(W)) stage0 (
      .clk(clk), .rst(rst), .en(cas_en), .clr(c_zero1), .load(c_zero1),
      .load_val(c_zero), .mod_max(c_mod), .sat(c_zero1),
      .qOut(q0), .tc(tc0), .carry(carry0), .ovf(ovf0)
   );

   sync_up_counter #(.WIDTH(W)) stage1 (
      .clk(clk), .rst(rst), .en(carry0), .clr(c_zero1), .load(c_zero1),
      .load_val(c_zero), .mod_max(c_mod), .sat(c_zero1),
      .qOut(q1), .tc(tc1), .carry(carry1), .ovf(ovf1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour of one rising edge, from the counter's rules
   task automatic model_edge();
      if (rst) begin
         m_q = 0; m_ovf = 0;
      end else if (clr) begin
         m_q = 0; m_ovf = 0;
      end else if (load) begin
         m_q = int'(load_val);
      end else if (en) begin
         if (m_q == int'(mod_max) || m_q == MODV - 1) begin
            if (!sat) begin
               m_q = 0; m_ovf = 1;
            end
         end else begin
            m_q = (m_q + 1) % MODV;
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic exp_tc;
      exp_tc = (m_q == int'(mod_max));
      chk({tag, ".q"},     32'(qOut),  32'(m_q));
      chk({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
      chk({tag, ".tc"},    32'(tc),    32'(exp_tc));
      chk({tag, ".carry"}, 32'(carry), 32'(exp_tc & en & ~clr & ~load));
   endtask

   // one edge: model follows the edge, outputs checked on the falling edge
   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(tag);
   endtask

   int e29[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
   int e30[8]  = '{1, 2, 3, 4, 5, 5, 5, 5};
   int e31[4]  = '{13, 14, 15, 0};

   initial begin
      rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; sat = 1'b0;
      load_val = '0; mod_max = 4'd9;
      cas_en = 1'b0; c_mod = 4'd9; c_zero = '0; c_zero1 = 1'b0;
      m_q = 0; m_ovf = 0;

      // reset state
      @(negedge clk);
      check_all("reset");
      chk("reset.q_lit", 32'(qOut), 0);
      step("reset_edge");
      rst = 1'b0;

      // wrap mod 10
      mod_max = 4'd9; sat = 1'b0; en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step("wrap10");
         chk("wrap10.q_lit",   32'(qOut), 32'(e29[i]));
         chk("wrap10.tc_lit",  32'(tc),   32'(e29[i] == 9));
         chk("wrap10.ovf_lit", 32'(ovf),  32'(i >= 9));
      end

      // saturate at 5
      en = 1'b0; clr = 1'b1; step("sat_clr"); clr = 1'b0;
      mod_max = 4'd5; sat = 1'b1; en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step("sat5");
         chk("sat5.q_lit",     32'(qOut),  32'(e30[i]));
         chk("sat5.ovf_lit",   32'(ovf),   0);
         chk("sat5.carry_lit", 32'(carry), 32'(e30[i] == 5));
      end

      // load above terminal, run through all-ones
      en = 1'b0; clr = 1'b1; step("above_clr"); clr = 1'b0;
      mod_max = 4'd9; sat = 1'b0; load = 1'b1; load_val = 4'd12;
      step("above_load");
      chk("above_load.q_lit", 32'(qOut), 12);
      load = 1'b0; en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step("above_run");
         chk("above_run.q_lit",  32'(qOut), 32'(e31[i]));
         chk("above_run.tc_lit", 32'(tc),   0);
      end
      chk("above_run.ovf_lit", 32'(ovf), 1);

      // clr beats load and en; ovf cleared
      en = 1'b0; load = 1'b1; load_val = 4'd3; step("prio_pre");
      load_val = 4'd7; clr = 1'b1; en = 1'b1;
      step("prio_clr");
      chk("prio_clr.q_lit",   32'(qOut), 0);
      chk("prio_clr.ovf_lit", 32'(ovf),  0);
      clr = 1'b0; en = 1'b0;
      step("prio_load");
      chk("prio_load.q_lit", 32'(qOut), 7);

      // async reset mid-count with ovf set
      load_val = 4'd9; step("ar_load9");
      load = 1'b0; en = 1'b1; step("ar_wrap");
      en = 1'b0; load = 1'b1; load_val = 4'd6; step("ar_load6");
      chk("ar_pre.q_lit",   32'(qOut), 6);
      chk("ar_pre.ovf_lit", 32'(ovf),  1);
      load = 1'b0;
      @(posedge clk);
      model_edge();
      #2 rst = 1'b1;
      #1;
      chk("ar_async.q_lit",   32'(qOut), 0);
      chk("ar_async.ovf_lit", 32'(ovf),  0);
      m_q = 0; m_ovf = 0;
      en = 1'b1; load = 1'b1; load_val = 4'd11; mod_max = 4'd0;
      for (int i = 0; i < 3; i++) begin
         step("ar_hold");
         chk("ar_hold.q_lit", 32'(qOut), 0);
      end
      rst = 1'b0; load = 1'b0; mod_max = 4'd9;
      step("ar_release");
      chk("ar_release.q_lit", 32'(qOut), 1);

      // randomized run against the model
      for (int i = 0; i < 3000; i++) begin
         clr  = ($urandom_range(0, 31) == 0);
         load = ($urandom_range(0, 9) == 0);
         en   = ($urandom_range(0, 3) != 0);
         load_val = W'($urandom_range(0, MODV - 1));
         if ($urandom_range(0, 7) == 0) mod_max = W'($urandom_range(0, MODV - 1));
         if ($urandom_range(0, 15) == 0) sat = ~sat;
         step("rand");
      end
      en = 1'b0; clr = 1'b0; load = 1'b0;

      // two-stage decade cascade
      cas_en = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk("cascade.q0",   32'(q0),   32'(k % 10));
         chk("cascade.q1",   32'(q1),   32'((k / 10) % 10));
         chk("cascade.ovf1", 32'(ovf1), 32'(k >= 100));
      end
      cas_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sync_up_counter.md
SYNC_UP_COUNTER -- requirements
Module: sync_up_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, counter width in bits (legal 2..16).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port en  input  1  count enable.
REQ-005 The block SHALL have port clr  input  1  synchronous clear of count and overflow flag.
REQ-006 The block SHALL have port load  input  1  synchronous parallel load.
REQ-007 The block SHALL have port load_val  input  WIDTH  value captured on load.
REQ-008 The block SHALL have port mod_max  input  WIDTH  terminal (highest) count value; sampled every cycle.
REQ-009 The block SHALL have port sat  input  1  0 = wrap at terminal, 1 = hold at terminal.
REQ-010 The block SHALL have port qOut  output  WIDTH  registered count.
REQ-011 The block SHALL have port tc  output  1  combinational, high while qOut == mod_max.
REQ-012 The block SHALL have port carry  output  1  combinational, tc AND en AND NOT clr AND NOT load; cascade enable for the next stage.
REQ-013 The block SHALL have port ovf  output  1  registered sticky flag, set on any wrap.

Function
REQ-014 Per-edge priority SHALL be: rst > clr > load > en > hold.
REQ-015 clr=1 SHALL set qOut to 0 and ovf to 0 on the next edge, regardless of load/en.
REQ-016 load=1 (clr=0) SHALL set qOut to load_val on the next edge; ovf unchanged; values above mod_max are loaded as-is.
REQ-017 en=1, qOut != mod_max, qOut != all-ones SHALL give qOut+1 on the next edge (latency 1 cycle).
REQ-018 en=1, qOut == mod_max, sat=0 SHALL give qOut=0 and ovf=1 on the next edge.
REQ-019 en=1, qOut == mod_max, sat=1 SHALL hold qOut; ovf unchanged.
REQ-020 en=1, qOut == all-ones != mod_max (count above terminal) SHALL give qOut=0 and ovf=1 if sat=0, hold if sat=1.
REQ-021 en=0 with clr=0, load=0 SHALL hold qOut and ovf.
REQ-022 A change of mod_max mid-count SHALL take effect on the same cycle's comparison; no internal copy is kept.
REQ-023 ovf SHALL remain 1 until clr or rst; a wrap and a clr on the same edge SHALL leave ovf=0.
REQ-024 All arithmetic SHALL be unsigned modulo 2^WIDTH; no output glitch requirement on combinational tc/carry.

Reset
REQ-025 rst=1 SHALL immediately (no clock needed) force qOut=0 and ovf=0.
REQ-026 While rst=1, clk edges, en, load and clr SHALL have no effect; tc and carry SHALL reflect qOut=0 vs mod_max.
REQ-027 On rst deassertion, the first rising clk edge with rst=0 SHALL apply normal priority.
REQ-028 Reset asserted mid-count SHALL abandon the count; no partial state survives.

Verification
REQ-029 WIDTH=4, mod_max=9, sat=0, en=1 from reset for 12 edges -> qOut 1..9,0,1,2; tc high while qOut=9; ovf=1 from the edge producing 0.
REQ-030 mod_max=5, sat=1, en=1 for 8 edges -> qOut 1..5 then holds 5; ovf stays 0; carry high while held.
REQ-031 load=1, load_val=12, mod_max=9, sat=0, then en=1 -> qOut 12,13,14,15,0; ovf=1 after 15->0; tc never high.
REQ-032 Same edge load=1, load_val=7, clr=1, en=1 at qOut=3 -> qOut=0, ovf=0; next edge with load only -> 7.
REQ-033 Assert rst between clk edges with qOut=6, ovf=1 -> qOut=0, ovf=0 before the next edge; edges during rst keep 0.
REQ-034 Two instances cascaded (stage1.en = stage0.carry), both mod_max=9 -> 100 edges return the pair to 0,0; stage1 ovf=1 at that point.
